recv: RTL and testbench

//  Receive side of the Darwin3 west-port REQ/ACK link; counterpart of `send`.
//  - Accepts 16-bit words over a 2-phase bundled-data handshake (RX_REQ/RX_DATA in, RX_ACK out).
//  - Buffers the words and re-emits them as an AXI4-Stream master toward the PC-side DMA.
//  - Frames output packets by word count or by an idle timeout.

---
 rtl/recv_pkg.sv | 24 ++
 rtl/recv_rx_fifo.sv | 56 +++++
 rtl/recv.sv | 171 +++++++++++++++++
 tb/tb_recv.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/recv_pkg.sv
// Shared link definitions for the Darwin3 west-port receive path.
package recv_pkg;

    localparam int unsigned LINK_DW    = 16;
    localparam logic [1:0]  TKEEP_FULL = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } frame_state_e;

    typedef struct packed {
        logic               last;
        logic [LINK_DW-1:0] data;
    } link_word_t;

    localparam int unsigned WORD_W = $bits(link_word_t);

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/recv_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; dout reads zero while empty.
module rx_fifo
    import recv_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int unsigned AW = cnt_width(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = wr_ptr_q + PW'(do_wr);
        rd_ptr_d = rd_ptr_q + PW'(do_rd);
        dout     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/recv.sv
// Receive side of the west-port 2-phase REQ/ACK link: captures words, frames
// them by count or idle timeout, and streams them out as AXI4-Stream.
module recv
    import recv_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned FRAME_LEN    = 64,
    parameter int unsigned IDLE_TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RX_REQ,
    input  logic [LINK_DW-1:0] RX_DATA,
    output logic               RX_ACK,
    output logic [LINK_DW-1:0] M_AXIS_TDATA,
    output logic               M_AXIS_TVALID,
    input  logic               M_AXIS_TREADY,
    output logic [1:0]         M_AXIS_TKEEP,
    output logic               M_AXIS_TLAST,
    output logic               RECV_DONE
);

    localparam int unsigned BEAT_W = cnt_width(FRAME_LEN);
    localparam int unsigned IDLE_W = cnt_width(IDLE_TIMEOUT);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FRAME_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
    logic                   ack_q, ack_d;
    frame_state_e           state_q, state_d;
    logic [LINK_DW-1:0]     pend_q, pend_d;
    logic                   force_last_q, force_last_d;
    logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
    logic                   done_q, done_d;

    logic                   req_s;
    logic                   capture;
    logic                   fifo_wr;
    logic                   fifo_rd;
    logic                   fifo_full;
    logic                   fifo_empty;
    link_word_t             push_word;
    link_word_t             head_word;
    logic [WORD_W-1:0]      fifo_dout;

    // A forced-last word owns the next FIFO write, so capture pauses for it.
    always_comb begin
        req_sync_d = {req_sync_q[SYNC_STAGES-2:0], RX_REQ};
        req_s      = req_sync_q[SYNC_STAGES-1];
        capture    = (req_s != ack_q) && !fifo_full &&
                     !((state_q == ST_HOLD) && force_last_q);
        ack_d      = ack_q ^ capture;
    end

    // Framing: the held word is pushed only once its TLAST is known.
    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        force_last_d   = force_last_q;
        beat_cnt_d     = beat_cnt_q;
        idle_cnt_d     = idle_cnt_q;
        fifo_wr        = 1'b0;
        push_word.last = 1'b0;
        push_word.data = pend_q;

        case (state_q)
            ST_IDLE: begin
                idle_cnt_d = '0;
                if (capture) begin
                    if (beat_cnt_q == BEAT_LAST) begin
                        fifo_wr        = 1'b1;
                        push_word.last = 1'b1;
                        push_word.data = RX_DATA;
                        beat_cnt_d     = '0;
                    end else begin
                        pend_d     = RX_DATA;
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                        state_d    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (force_last_q) begin
                    if (!fifo_full) begin
                        fifo_wr        = 1'b1;
                        push_word.last = 1'b1;
                        force_last_d   = 1'b0;
                        beat_cnt_d     = '0;
                        idle_cnt_d     = '0;
                        state_d        = ST_IDLE;
                    end
                end else if (capture) begin
                    fifo_wr    = 1'b1;
                    idle_cnt_d = '0;
                    pend_d     = RX_DATA;
                    if (beat_cnt_q == BEAT_LAST) begin
                        force_last_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end else if (idle_cnt_q == IDLE_LAST) begin
                    // Timeout waits at its terminal count until the FIFO has room.
                    if (!fifo_full) begin
                        fifo_wr        = 1'b1;
                        push_word.last = 1'b1;
                        beat_cnt_d     = '0;
                        idle_cnt_d     = '0;
                        state_d        = ST_IDLE;
                    end
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        head_word = link_word_t'(fifo_dout);
        fifo_rd   = !fifo_empty && M_AXIS_TREADY;
        done_d    = fifo_rd && head_word.last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_sync_q   <= '0;
            ack_q        <= 1'b0;
            state_q      <= ST_IDLE;
            pend_q       <= '0;
            force_last_q <= 1'b0;
            beat_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            req_sync_q   <= req_sync_d;
            ack_q        <= ack_d;
            state_q      <= state_d;
            pend_q       <= pend_d;
            force_last_q <= force_last_d;
            beat_cnt_q   <= beat_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            done_q       <= done_d;
        end
    end

    rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (fifo_wr),
        .din   (push_word),
        .full  (fifo_full),
        .rd_en (fifo_rd),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    assign RX_ACK        = ack_q;
    assign M_AXIS_TDATA  = head_word.data;
    assign M_AXIS_TLAST  = head_word.last;
    assign M_AXIS_TVALID = !fifo_empty;
    assign M_AXIS_TKEEP  = TKEEP_FULL;
    assign RECV_DONE     = done_q;

endmodule

// File: tb/tb_recv.sv
// Directed bench for recv: two instances (short frames / small FIFO + short timeout).
module tb_recv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [2];
    logic        rx_req   [2];
    logic [15:0] rx_data  [2];
    logic        rx_ack   [2];
    logic [15:0] tdata    [2];
    logic        tvalid   [2];
    logic        tready   [2];
    logic [1:0]  tkeep    [2];
    logic        tlast    [2];
    logic        done     [2];
    logic        rand_rdy [2];

    // Instance 0: frame by count (4), deep FIFO, long timeout.
    recv #(.SYNC_STAGES(2), .FIFO_DEPTH(16), .FRAME_LEN(4), .IDLE_TIMEOUT(256)) dut_a (
        .clk(clk), .rst(rst[0]), .RX_REQ(rx_req[0]), .RX_DATA(rx_data[0]), .RX_ACK(rx_ack[0]),
        .M_AXIS_TDATA(tdata[0]), .M_AXIS_TVALID(tvalid[0]), .M_AXIS_TREADY(tready[0]),
        .M_AXIS_TKEEP(tkeep[0]), .M_AXIS_TLAST(tlast[0]), .RECV_DONE(done[0])
    );

    // Instance 1: long frames, 4-entry FIFO, 16-cycle idle flush.
    recv #(.SYNC_STAGES(2), .FIFO_DEPTH(4), .FRAME_LEN(64), .IDLE_TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst[1]), .RX_REQ(rx_req[1]), .RX_DATA(rx_data[1]), .RX_ACK(rx_ack[1]),
        .M_AXIS_TDATA(tdata[1]), .M_AXIS_TVALID(tvalid[1]), .M_AXIS_TREADY(tready[1]),
        .M_AXIS_TKEEP(tkeep[1]), .M_AXIS_TLAST(tlast[1]), .RECV_DONE(done[1])
    );

    // Chip-side sender: one word per completed 2-phase handshake.
    logic [15:0] tx_mem   [2][256];
    int          tx_wr    [2];
    int          tx_rd    [2];
    logic        chip_rst [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            rx_req[d] = 1'b0; rx_data[d] = 16'h0000;
            tx_wr[d] = 0; tx_rd[d] = 0; chip_rst[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (chip_rst[d]) begin
                    rx_req[d] = 1'b0;
                    tx_rd[d]  = tx_wr[d];
                end else if (rx_req[d] === rx_ack[d] && tx_rd[d] != tx_wr[d]) begin
                    rx_data[d] = tx_mem[d][8'(tx_rd[d])];
                    rx_req[d]  = ~rx_req[d];
                    tx_rd[d]++;
                end
            end
        end
    end

    // Stream monitor, sampled between edges.
    logic [16:0] rx_mem   [2][512];
    int          rx_cnt   [2];
    int          done_cnt [2];
    int          ack_tog  [2];
    int          keep_bad [2];
    logic        ack_prev [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            rx_cnt[d] = 0; done_cnt[d] = 0; ack_tog[d] = 0; keep_bad[d] = 0; ack_prev[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (tvalid[d] === 1'b1 && tready[d] === 1'b1) begin
                    rx_mem[d][9'(rx_cnt[d])] = {tlast[d], tdata[d]};
                    rx_cnt[d]++;
                    if (tkeep[d] !== 2'b11) keep_bad[d]++;
                end
                if (done[d] === 1'b1) done_cnt[d]++;
                if (rx_ack[d] !== ack_prev[d]) begin
                    ack_tog[d]++;
                    ack_prev[d] = rx_ack[d];
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rand_rdy[d]) tready[d] = ($urandom_range(0, 1) == 1);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int d, input logic [15:0] w);
        tx_mem[d][8'(tx_wr[d])] = w;
        tx_wr[d]++;
    endtask

    task automatic clear_counts(input int d);
        rx_cnt[d] = 0; done_cnt[d] = 0; ack_tog[d] = 0; keep_bad[d] = 0;
    endtask

    task automatic wait_beats(input int d, input int n, input int budget);
        int t;
        t = 0;
        while (rx_cnt[d] < n && t < budget) begin
            @(negedge clk);
            t++;
        end
    endtask

    int   n;
    int   lat;
    logic prev;
    logic stable_ok;

    initial begin
        rst[0] = 1'b1; rst[1] = 1'b1;
        tready[0] = 1'b0; tready[1] = 1'b0;
        rand_rdy[0] = 1'b0; rand_rdy[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack_a",    32'(rx_ack[0]), 32'd0);
        check("rst_tvalid_a", 32'(tvalid[0]), 32'd0);
        check("rst_tlast_a",  32'(tlast[0]),  32'd0);
        check("rst_tdata_a",  32'(tdata[0]),  32'd0);
        check("rst_done_a",   32'(done[0]),   32'd0);
        check("rst_tvalid_b", 32'(tvalid[1]), 32'd0);
        check("rst_ack_b",    32'(rx_ack[1]), 32'd0);

        @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        tready[0] = 1'b1; tready[1] = 1'b1;
        clear_counts(0); clear_counts(1);

        // Frame by count, plus REQ->ACK latency on the first word.
        @(negedge clk);
        #1;
        send(0, 16'h0001);
        n = 0;
        while (rx_req[0] !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
        lat = 0;
        while (rx_ack[0] !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        check("req_ack_latency", 32'(lat), 32'd3);
        send(0, 16'h0002); send(0, 16'h0003); send(0, 16'h0004);
        wait_beats(0, 4, 200);
        repeat (5) @(negedge clk);
        check("cnt_beats", 32'(rx_cnt[0]), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("cnt_data", 32'(rx_mem[0][9'(i)][15:0]), 32'(i + 1));
            check("cnt_last", 32'(rx_mem[0][9'(i)][16]), (i == 3) ? 32'd1 : 32'd0);
        end
        check("cnt_done",     32'(done_cnt[0]), 32'd1);
        check("cnt_ack_togs", 32'(ack_tog[0]),  32'd4);
        check("cnt_keep",     32'(keep_bad[0]), 32'd0);

        // Idle flush on instance 1: second word closes the packet 16 cycles after capture.
        @(negedge clk);
        clear_counts(1);
        prev = rx_ack[1];
        send(1, 16'h00A0); send(1, 16'h00A1);
        n = 0;
        while (n < 2 && lat < 1000) begin
            @(posedge clk); #1;
            if (rx_ack[1] !== prev) begin n++; prev = rx_ack[1]; end
            lat++;
        end
        lat = 0;
        while (!(tvalid[1] === 1'b1 && tdata[1] === 16'h00A1) && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check("idle_flush_delay", 32'(lat), 32'd16);
        check("idle_flush_tlast", 32'(tlast[1]), 32'd1);
        wait_beats(1, 2, 100);
        check("idle_beats", 32'(rx_cnt[1]), 32'd2);
        check("idle_w0",    32'(rx_mem[1][0]), 32'h0_00A0);
        check("idle_w1",    32'(rx_mem[1][1]), 32'h1_00A1);

        // Backpressure on instance 1: four FIFO entries plus the held word.
        @(negedge clk);
        tready[1] = 1'b0;
        clear_counts(1);
        for (int i = 0; i < 8; i++) send(1, 16'h0B01 + 16'(i));
        repeat (60) @(negedge clk);
        check("bp_acks_stalled", 32'(ack_tog[1]), 32'd5);
        check("bp_tvalid",       32'(tvalid[1]),  32'd1);
        stable_ok = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (tdata[1] !== 16'h0B01 || tvalid[1] !== 1'b1) stable_ok = 1'b0;
        end
        check("bp_head_stable", 32'(stable_ok), 32'd1);
        @(negedge clk);
        tready[1] = 1'b1;
        wait_beats(1, 8, 400);
        repeat (30) @(negedge clk);
        check("bp_beats", 32'(rx_cnt[1]), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("bp_data", 32'(rx_mem[1][9'(i)][15:0]), 32'(16'h0B01 + 16'(i)));
        end
        check("bp_final_last", 32'(rx_mem[1][7][16]), 32'd1);
        check("bp_ack_togs",   32'(ack_tog[1]),        32'd8);

        // Random TREADY, 200 counting words on instance 0.
        @(negedge clk);
        clear_counts(0);
        rand_rdy[0] = 1'b1;
        for (int i = 0; i < 200; i++) send(0, 16'(i + 1));
        wait_beats(0, 200, 8000);
        rand_rdy[0] = 1'b0;
        @(negedge clk);
        tready[0] = 1'b1;
        repeat (10) @(negedge clk);
        check("rnd_beats", 32'(rx_cnt[0]), 32'd200);
        for (int i = 0; i < 200; i++) begin
            check("rnd_data", 32'(rx_mem[0][9'(i)][15:0]), 32'(i + 1));
            check("rnd_last", 32'(rx_mem[0][9'(i)][16]), ((i % 4) == 3) ? 32'd1 : 32'd0);
        end
        check("rnd_done", 32'(done_cnt[0]), 32'd50);
        check("rnd_keep", 32'(keep_bad[0]), 32'd0);

        // Reset mid-frame on instance 0 with the sender reset alongside.
        @(negedge clk);
        tready[0] = 1'b0;
        clear_counts(0);
        send(0, 16'h0201); send(0, 16'h0202); send(0, 16'h0203);
        n = 0;
        while (ack_tog[0] < 3 && n < 200) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        check("mr_acks",        32'(ack_tog[0]), 32'd3);
        check("mr_tvalid_pre",  32'(tvalid[0]),  32'd1);
        @(negedge clk);
        rst[0] = 1'b1;
        chip_rst[0] = 1'b1;
        @(posedge clk); #1;
        check("mr_tvalid_post", 32'(tvalid[0]), 32'd0);
        check("mr_ack_post",    32'(rx_ack[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        @(negedge clk);
        chip_rst[0] = 1'b0;
        tready[0] = 1'b1;
        clear_counts(0);
        for (int i = 0; i < 4; i++) send(0, 16'h0101 + 16'(i));
        wait_beats(0, 4, 200);
        repeat (20) @(negedge clk);
        check("mr_beats", 32'(rx_cnt[0]), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("mr_data", 32'(rx_mem[0][9'(i)][15:0]), 32'(16'h0101 + 16'(i)));
            check("mr_last", 32'(rx_mem[0][9'(i)][16]), (i == 3) ? 32'd1 : 32'd0);
        end
        check("mr_done", 32'(done_cnt[0]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
